// File: rtl/led_cnt_bank_if.sv
// Configuration write bus for led_cnt_bank.
//   wr_en   : write strobe (master -> slave)
//   wr_ch   : target channel, ChW = max(1, clog2(NUM_CH)) bits
//   wr_div  : divisor; 0 selects the fixed one-second half-period
//   wr_mode : 00 OFF, 01 BLINK, 10 ONESHOT, 11 ON
//   wr_rdy  : 1 = a write presented this cycle is accepted (slave -> master)
interface led_cnt_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 12
);
  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             wr_en;
  logic [ChW-1:0]   wr_ch;
  logic [DIV_W-1:0] wr_div;
  logic [1:0]       wr_mode;
  logic             wr_rdy;

  modport master (output wr_en, wr_ch, wr_div, wr_mode, input wr_rdy);
  modport slave  (input wr_en, wr_ch, wr_div, wr_mode, output wr_rdy);
endinterface

// File: rtl/led_cnt_bank.sv
// Multi-channel LED blink generator. Each channel runs a half-period counter and toggles its LED
// when the counter reaches the channel period. Periods are MAX_CNT/div (clamped to >=1), or
// SEC1_CNT for div==0, produced by one shared restoring divider (one quotient bit per cycle).
// Rising LED edges set sticky, maskable status bits and start stretched per-channel IRQ pulses.
// Ports:
//   clk100, rst_n : clock, asynchronous active-low reset
//   wr_bus_io     : configuration write bus (slave side)
//   irq_en_i      : interrupt mask per channel
//   irq_clr_i     : write-one-to-clear for irq_status_o
//   led_o         : LED outputs
//   mode_o        : current mode per channel, ch0 in [1:0]
//   irq_status_o  : sticky rise status
//   irq_pulse_o   : INT_STRETCH-cycle pulse per rising LED edge
//   irq_o         : OR of masked status
module led_cnt_bank #(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      DIV_W       = 12,
  parameter int unsigned      CNT_W       = 32,
  parameter logic [CNT_W-1:0] MAX_CNT     = '1,
  parameter logic [CNT_W-1:0] SEC1_CNT    = CNT_W'(32'h05F5_E100),
  parameter logic [1:0]       RST_MODE    = 2'b01,
  parameter int unsigned      INT_STRETCH = 21
) (
  input  logic                clk100,
  input  logic                rst_n,
  led_cnt_bank_if.slave       wr_bus_io,
  input  logic [NUM_CH-1:0]   irq_en_i,
  input  logic [NUM_CH-1:0]   irq_clr_i,
  output logic [NUM_CH-1:0]   led_o,
  output logic [2*NUM_CH-1:0] mode_o,
  output logic [NUM_CH-1:0]   irq_status_o,
  output logic [NUM_CH-1:0]   irq_pulse_o,
  output logic                irq_o
);
  localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BitW   = $clog2(CNT_W + 1);
  localparam int unsigned PulseW = $clog2(INT_STRETCH + 1);
  localparam logic [BitW-1:0]   BitsL    = BitW'(CNT_W);
  localparam logic [PulseW-1:0] StretchL = PulseW'(INT_STRETCH);

  localparam logic [1:0] ModeOff     = 2'b00;
  localparam logic [1:0] ModeBlink   = 2'b01;
  localparam logic [1:0] ModeOneshot = 2'b10;
  localparam logic [1:0] ModeOn      = 2'b11;

  typedef enum logic [0:0] {StIdle, StDiv} state_e;
  state_e state_q, state_d;

  // Divider state
  logic [ChW-1:0]   div_ch_q, div_ch_d;
  logic [DIV_W-1:0] dvsr_q, dvsr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] quo_q, quo_d;  // dividend shifts out of the top, quotient in at the bottom
  logic [BitW-1:0]  bit_q, bit_d;

  logic [CNT_W:0]   rem_sh, dvsr_ext;
  logic             q_bit;
  logic [CNT_W-1:0] rem_nxt, quo_nxt, quo_clamp;

  // Channel state
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [1:0]        mode_q [NUM_CH];
  logic [1:0]        mode_d [NUM_CH];
  logic [PulseW-1:0] pulse_q [NUM_CH];
  logic [PulseW-1:0] pulse_d [NUM_CH];
  logic [NUM_CH-1:0] led_q, led_d, led_prev_q;
  logic [NUM_CH-1:0] status_q, status_d;
  logic [NUM_CH-1:0] rise;

  logic [31:0] wr_ch_ext, div_ch_ext;
  logic        wr_acc, wr_ch_ok, div_start, div_done;

  assign wr_ch_ext  = 32'(wr_bus_io.wr_ch);
  assign div_ch_ext = 32'(div_ch_q);
  assign wr_acc     = wr_bus_io.wr_en && (state_q == StIdle);
  assign wr_ch_ok   = wr_ch_ext < NUM_CH;
  // Out-of-range channels are accepted but never start the divider
  assign div_start  = wr_acc && wr_ch_ok && (wr_bus_io.wr_div != '0);
  assign div_done   = (state_q == StDiv) && (bit_q == BitW'(1));

  // FSM: state register
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (div_start) state_d = StDiv;
      StDiv:   if (div_done)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    wr_bus_io.wr_rdy = (state_q == StIdle);
  end

  // One restoring-division step
  always_comb begin
    rem_sh              = {rem_q, quo_q[CNT_W-1]};
    dvsr_ext            = '0;
    dvsr_ext[DIV_W-1:0] = dvsr_q;
    q_bit               = (rem_sh >= dvsr_ext);
    // The true difference is below the divisor, so the low CNT_W bits are exact
    rem_nxt   = q_bit ? (rem_sh[CNT_W-1:0] - dvsr_ext[CNT_W-1:0]) : rem_sh[CNT_W-1:0];
    quo_nxt   = {quo_q[CNT_W-2:0], q_bit};
    quo_clamp = (quo_nxt == '0) ? CNT_W'(1) : quo_nxt;
  end

  always_comb begin
    div_ch_d = div_ch_q;
    dvsr_d   = dvsr_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    bit_d    = bit_q;
    if (div_start) begin
      div_ch_d = wr_bus_io.wr_ch;
      dvsr_d   = wr_bus_io.wr_div;
      rem_d    = '0;
      quo_d    = MAX_CNT;
      bit_d    = BitsL;
    end else if (state_q == StDiv) begin
      rem_d = rem_nxt;
      quo_d = quo_nxt;
      bit_d = bit_q - BitW'(1);
    end
  end

  // Channel counters, LEDs and modes
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    mode_d   = mode_q;
    led_d    = led_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (wr_acc && wr_ch_ok && (wr_ch_ext == c)) begin
        mode_d[c] = wr_bus_io.wr_mode;
        cnt_d[c]  = '0;
        // ONESHOT starts from a dark LED so its two toggles give exactly one lit phase
        if (wr_bus_io.wr_mode == ModeOn) begin
          led_d[c] = 1'b1;
        end else if (wr_bus_io.wr_mode != ModeBlink) begin
          led_d[c] = 1'b0;
        end
        if (wr_bus_io.wr_div == '0) period_d[c] = SEC1_CNT;
      end else if ((state_q == StDiv) && (div_ch_ext == c)) begin
        // Target channel is held until its new period lands
        cnt_d[c] = '0;
        if (div_done) period_d[c] = quo_clamp;
      end else begin
        unique case (mode_q[c])
          ModeOff: begin
            cnt_d[c] = '0;
            led_d[c] = 1'b0;
          end
          ModeOn: begin
            cnt_d[c] = '0;
            led_d[c] = 1'b1;
          end
          ModeBlink, ModeOneshot: begin
            if (cnt_q[c] >= period_q[c]) begin
              cnt_d[c] = '0;
              if ((mode_q[c] == ModeOneshot) && led_q[c]) begin
                led_d[c]  = 1'b0;
                mode_d[c] = ModeOff;
              end else begin
                led_d[c] = ~led_q[c];
              end
            end else begin
              cnt_d[c] = cnt_q[c] + CNT_W'(1);
            end
          end
          default: cnt_d[c] = '0;
        endcase
      end
    end
  end

  // Interrupt status and stretched pulses
  always_comb begin
    rise     = led_q & ~led_prev_q;
    status_d = (status_q & ~irq_clr_i) | rise;  // a new rise beats a same-cycle clear
    pulse_d  = pulse_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rise[c]) begin
        pulse_d[c] = StretchL;
      end else if (pulse_q[c] != '0) begin
        pulse_d[c] = pulse_q[c] - PulseW'(1);
      end
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '{default: '0};
      period_q   <= '{default: SEC1_CNT};
      mode_q     <= '{default: RST_MODE};
      pulse_q    <= '{default: '0};
      led_q      <= '0;
      led_prev_q <= '0;
      status_q   <= '0;
      div_ch_q   <= '0;
      dvsr_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      bit_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      mode_q     <= mode_d;
      pulse_q    <= pulse_d;
      led_q      <= led_d;
      led_prev_q <= led_q;
      status_q   <= status_d;
      div_ch_q   <= div_ch_d;
      dvsr_q     <= dvsr_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      bit_q      <= bit_d;
    end
  end

  always_comb begin
    led_o        = led_q;
    irq_status_o = status_q;
    irq_o        = |(status_q & irq_en_i);
    mode_o       = '0;
    irq_pulse_o  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      mode_o[2*c +: 2] = mode_q[c];
      irq_pulse_o[c]   = (pulse_q[c] != '0);
    end
  end

endmodule

// File: tb/tb_led_cnt_bank.sv
// Directed bench for led_cnt_bank with small periods (MAX_CNT=1000, SEC1_CNT=100, CNT_W=16).
module tb_led_cnt_bank;
  localparam int unsigned NumCh = 4;
  localparam int unsigned DivW  = 12;
  localparam int unsigned CntW  = 16;

  logic       clk100 = 1'b0;
  logic       rst_n  = 1'b1;
  logic [3:0] irq_en  = '0;
  logic [3:0] irq_clr = '0;
  logic [3:0] led, status, pulse;
  logic [7:0] mode;
  logic       irq;

  int tests = 0;
  int fails = 0;
  int n;
  int lows;
  int hi_cnt;

  led_cnt_bank_if #(.NUM_CH(NumCh), .DIV_W(DivW)) wr_bus ();

  led_cnt_bank #(
    .NUM_CH      (NumCh),
    .DIV_W       (DivW),
    .CNT_W       (CntW),
    .MAX_CNT     (16'd1000),
    .SEC1_CNT    (16'd100),
    .RST_MODE    (2'b01),
    .INT_STRETCH (4)
  ) dut (
    .clk100       (clk100),
    .rst_n        (rst_n),
    .wr_bus_io    (wr_bus),
    .irq_en_i     (irq_en),
    .irq_clr_i    (irq_clr),
    .led_o        (led),
    .mode_o       (mode),
    .irq_status_o (status),
    .irq_pulse_o  (pulse),
    .irq_o        (irq)
  );

  always #5 clk100 = ~clk100;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Cycles until led[ch] changes; -1 if it does not within the budget.
  task automatic wait_toggle(input int ch, output int cnt);
    logic start;
    start = led[ch];
    cnt   = -1;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (led[ch] !== start) begin
        cnt = k;
        return;
      end
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [11:0] div, input logic [1:0] md);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_ch   = ch;
    wr_bus.wr_div  = div;
    wr_bus.wr_mode = md;
    tick();
    wr_bus.wr_en = 1'b0;
  endtask

  // Number of consecutive samples with wr_rdy low, starting now.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (wr_bus.wr_rdy === 1'b0 && cnt < 64) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    wr_bus.wr_en   = 1'b0;
    wr_bus.wr_ch   = '0;
    wr_bus.wr_div  = '0;
    wr_bus.wr_mode = '0;

    // 1: reset and first toggle 101 cycles after release
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_led", 32'(led), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdy", 32'(wr_bus.wr_rdy), 32'h1);
    check("rst_mode", 32'(mode), 32'h55);
    check("rst_status", 32'(status), 32'h0);
    check("rst_pulse", 32'(pulse), 32'h0);
    repeat (100) tick();
    check("t1_before_toggle", 32'(led), 32'h0);
    tick();
    check("t1_toggle_101", 32'(led), 32'hF);

    // 5: status, mask, pulse stretch, set beats clear
    tick();
    check("t5_status_set", 32'(status), 32'hF);
    check("t5_irq_masked", 32'(irq), 32'h0);
    check("t5_pulse_start", 32'(pulse), 32'hF);
    irq_en = 4'b0001;
    #1;
    check("t5_irq_unmasked", 32'(irq), 32'h1);
    repeat (3) tick();
    check("t5_pulse_last", 32'(pulse), 32'hF);
    tick();
    check("t5_pulse_end", 32'(pulse), 32'h0);
    irq_clr = 4'hF;
    tick();
    irq_clr = 4'h0;
    check("t5_cleared", 32'(status), 32'h0);
    check("t5_irq_cleared", 32'(irq), 32'h0);
    wait_toggle(0, n);  // falling edge
    wait_toggle(0, n);  // next rise
    check("t5_ch0_half_period", 32'(n), 32'd101);
    irq_clr = 4'b0001;  // same cycle as the rise
    tick();
    irq_clr = 4'h0;
    check("t5_set_wins", 32'(status), 32'hF);
    check("t5_irq_after_set", 32'(irq), 32'h1);
    irq_clr = 4'hF;
    tick();
    irq_clr = 4'h0;

    // 2 + 4: ch1 div=3 BLINK, ch3 write during busy is ignored
    wr(2'd1, 12'd3, 2'b01);
    lows = 0;
    for (int i = 0; i < 64 && wr_bus.wr_rdy === 1'b0; i++) begin
      if (i == 3) begin
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_ch   = 2'd3;
        wr_bus.wr_div  = 12'd5;
        wr_bus.wr_mode = 2'b11;
      end else begin
        wr_bus.wr_en = 1'b0;
      end
      lows++;
      tick();
    end
    wr_bus.wr_en = 1'b0;
    check("t2_busy_cycles", 32'(lows), 32'd16);
    check("t4_ch3_mode_kept", 32'(mode[7:6]), 32'h1);
    wait_toggle(1, n);
    check("t2_ch1_first", 32'(n), 32'd334);
    wait_toggle(1, n);
    check("t2_ch1_half_period", 32'(n), 32'd334);
    wait_toggle(3, n);
    wait_toggle(3, n);
    check("t4_ch3_period_kept", 32'(n), 32'd101);

    // 3: ch2 div=4095 -> quotient 0 clamped to 1
    wr(2'd2, 12'd4095, 2'b01);
    wait_idle(lows);
    check("t3_busy_cycles", 32'(lows), 32'd16);
    wait_toggle(2, n);
    check("t3_ch2_first", 32'(n), 32'd2);
    wait_toggle(2, n);
    check("t3_ch2_half_period", 32'(n), 32'd2);
    hi_cnt = 0;
    repeat (20) begin
      tick();
      if (pulse[2] === 1'b1) hi_cnt++;
    end
    check("t3_pulse_restart", 32'(hi_cnt), 32'd20);

    // 6: ONESHOT ch1 div=10
    wr(2'd1, 12'd10, 2'b10);
    wait_idle(lows);
    check("t6_busy_cycles", 32'(lows), 32'd16);
    check("t6_led_cleared", 32'(led[1]), 32'h0);
    check("t6_mode_oneshot", 32'(mode[3:2]), 32'h2);
    wait_toggle(1, n);
    check("t6_low_phase", 32'(n), 32'd101);
    check("t6_led_high", 32'(led[1]), 32'h1);
    wait_toggle(1, n);
    check("t6_high_phase", 32'(n), 32'd101);
    check("t6_mode_off", 32'(mode[3:2]), 32'h0);
    repeat (150) tick();
    check("t6_stays_off", 32'(led[1]), 32'h0);

    // 6: reset in the middle of a divide
    wr(2'd0, 12'd7, 2'b01);
    repeat (5) tick();
    check("t6_busy_before_rst", 32'(wr_bus.wr_rdy), 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rdy", 32'(wr_bus.wr_rdy), 32'h1);
    check("t6_rst_led", 32'(led), 32'h0);
    check("t6_rst_mode", 32'(mode), 32'h55);
    check("t6_rst_status", 32'(status), 32'h0);
    check("t6_rst_pulse", 32'(pulse), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    check("t6_after_rst_before", 32'(led), 32'h0);
    tick();
    check("t6_after_rst_period100", 32'(led), 32'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
